// File: rtl/ttl_74148_latched.sv
// Latched 74148-style priority encoder: sticky request capture, code held until Ack, one-cycle gap after.
// Define TTL_74148_LATCHED_LEVEL_EN for level-sensitive requests (default: falling-edge capture).
module ttl_74148_latched #(
   parameter int WIDTH_IN   = 8,
   parameter int WIDTH_OUT  = $clog2(WIDTH_IN),
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input  logic                 Clk,
   input  logic                 Clear_bar,
   input  logic                 Enable_bar,
   input  logic [WIDTH_IN-1:0]  D_bar,
   input  logic                 Ack,
   output logic [WIDTH_OUT-1:0] A_bar,
   output logic                 GS_bar,
   output logic                 EO_bar
);

   typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_RECOVER} state_t;

   state_t               r_state;
   logic [WIDTH_OUT-1:0] r_code;
   logic [WIDTH_IN-1:0]  r_pending;
   logic [WIDTH_IN-1:0]  w_set;
   logic [WIDTH_IN-1:0]  w_clr;
   logic [WIDTH_OUT-1:0] w_top;
   logic                 w_present;

   // Propagation delays have no synthesizable meaning; they are accepted for pin compatibility only.
   if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_delay_unused
   end

`ifdef TTL_74148_LATCHED_LEVEL_EN
   assign w_set = ~D_bar;
`else
   logic [WIDTH_IN-1:0] r_d_prev;

   always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar) r_d_prev <= '1;
      else            r_d_prev <= D_bar;
   end

   assign w_set = r_d_prev & ~D_bar;
`endif

   // Ascending scan: the last hit is the highest pending index.
   always_comb begin
      w_top = '0;
      for (int i = 0; i < WIDTH_IN; i++)
         if (r_pending[i]) w_top = WIDTH_OUT'(i);
   end

   always_comb begin
      w_clr = '0;
      if (r_state == S_PRESENT && Ack) w_clr[r_code] = 1'b1;
   end

   always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar) begin
         r_state   <= S_IDLE;
         r_code    <= '0;
         r_pending <= '0;
      end else begin
         // set is OR'd after clear so a re-request on the acked bit survives
         r_pending <= (r_pending & ~w_clr) | w_set;
         case (r_state)
            S_IDLE: begin
               if (!Enable_bar && r_pending != '0) begin
                  r_code  <= w_top;
                  r_state <= S_PRESENT;
               end
            end
            S_PRESENT: if (Ack) r_state <= S_RECOVER;
            S_RECOVER: r_state <= S_IDLE;
            default:   r_state <= S_IDLE;
         endcase
      end
   end

   assign w_present = Clear_bar && !Enable_bar && r_state == S_PRESENT;
   assign A_bar     = w_present ? ~r_code : '1;
   assign GS_bar    = ~w_present;
   assign EO_bar    = ~(Clear_bar && !Enable_bar && r_state == S_IDLE && r_pending == '0);

endmodule

// File: tb/tb_ttl_74148_latched.sv
// Scoreboard bench for ttl_74148_latched: directed test-plan scenarios plus random traffic vs. a behavioural model.
module tb_ttl_74148_latched;

   logic       Clk = 1'b0;
   logic       Clear_bar, Enable_bar, Ack;
   logic [7:0] D_bar;
   logic [2:0] A_bar;
   logic       GS_bar, EO_bar;

   ttl_74148_latched #(.WIDTH_IN(8)) dut (
      .Clk(Clk), .Clear_bar(Clear_bar), .Enable_bar(Enable_bar), .D_bar(D_bar),
      .Ack(Ack), .A_bar(A_bar), .GS_bar(GS_bar), .EO_bar(EO_bar)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [2:0] a;
      logic       gs;
      logic       eo;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // Behavioural model: a set of outstanding requests plus "what is on the pins" phase.
   bit [7:0] m_pend;
   bit [7:0] m_prev;
   int       m_phase;   // 0 waiting, 1 showing a code, 2 forced gap
   int       m_code;
   bit       m_rst;

   function automatic int highest(input bit [7:0] p);
      for (int i = 7; i >= 0; i--) if (p[i]) return i;
      return -1;
   endfunction

   function automatic exp_t expect_now(input bit en_bar);
      exp_t e;
      bit   show;
      show = !m_rst && !en_bar && m_phase == 1;
      e.a  = show ? 3'(~m_code) : 3'b111;
      e.gs = !show;
      e.eo = !(!m_rst && !en_bar && m_phase == 0 && m_pend == 8'h00);
      return e;
   endfunction

   task automatic model_edge(input bit en_bar, input bit [7:0] d, input bit ack);
      bit [7:0] newreq;
      bit [7:0] served;
      int       top;
`ifdef TTL_74148_LATCHED_LEVEL_EN
      newreq = ~d;
`else
      newreq = m_prev & ~d;
      m_prev = d;
`endif
      served = 8'h00;
      top    = highest(m_pend);
      if (m_phase == 0) begin
         if (!en_bar && top >= 0) begin
            m_code  = top;
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (ack) begin
            served[m_code] = 1'b1;
            m_phase        = 2;
         end
      end else begin
         m_phase = 0;
      end
      m_pend = (m_pend & ~served) | newreq;
   endtask

   // Called just after a rising edge: drive, predict this cycle's outputs, advance across the next edge.
   task automatic step(input bit rst, input bit en_bar, input bit [7:0] d, input bit ack);
      Clear_bar  = !rst;
      Enable_bar = en_bar;
      D_bar      = d;
      Ack        = ack;
      m_rst      = rst;
      if (rst) begin
         m_pend  = 8'h00;
         m_prev  = 8'hFF;
         m_phase = 0;
         m_code  = 0;
      end
      q.push_back(expect_now(en_bar));
      @(posedge Clk);
      if (!rst) model_edge(en_bar, d, ack);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge Clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if ({A_bar, GS_bar, EO_bar} !== e) begin
               errors++;
               $display("FAIL outputs @%0t: got A_bar=%b GS_bar=%b EO_bar=%b expected A_bar=%b GS_bar=%b EO_bar=%b",
                        $time, A_bar, GS_bar, EO_bar, e.a, e.gs, e.eo);
            end
         end
      end
   end

   initial begin : stim
      logic [7:0] d_r;
      Clear_bar = 1'b0; Enable_bar = 1'b0; D_bar = 8'h00; Ack = 1'b0;
      m_pend = 8'h00; m_prev = 8'hFF; m_phase = 0; m_code = 0; m_rst = 1'b1;
      @(posedge Clk); #1;

      // reset with all lines low, then two edges to the first code
      step(1, 0, 8'h00, 0);
      step(1, 0, 8'h00, 0);
      chk("rst_A_bar", 8'(A_bar), 8'h07);
      chk("rst_GS_bar", 8'(GS_bar), 8'h01);
      chk("rst_EO_bar", 8'(EO_bar), 8'h01);
      step(0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);
      chk("first_GS_bar", 8'(GS_bar), 8'h00);
      chk("first_A_bar", 8'(A_bar), 8'h00);
      for (int i = 0; i < 30; i++) step(0, 0, 8'hFF, 1);

      // priority and hold
      step(0, 0, 8'hFB, 0);
      step(0, 0, 8'hFF, 0);
      step(0, 0, 8'hDF, 0);
      step(0, 0, 8'hFF, 0);
      step(0, 0, 8'hFF, 0);
      chk("hold_code2", 8'(A_bar), 8'h05);
      step(0, 0, 8'hFF, 1);
      chk("recover_gap", 8'(GS_bar), 8'h01);
      step(0, 0, 8'hFF, 0);
      step(0, 0, 8'hFF, 0);
      chk("next_code5", 8'(A_bar), 8'h02);
      step(0, 0, 8'hFF, 1);
      step(0, 0, 8'hFF, 0);
      chk("drained_EO", 8'(EO_bar), 8'h00);

      // simultaneous set and clear on bit 3
      step(0, 0, 8'hF7, 0);
      step(0, 0, 8'hFF, 0);
      step(0, 0, 8'hFF, 0);
      step(0, 0, 8'hF7, 1);
      step(0, 0, 8'hFF, 0);
      step(0, 0, 8'hFF, 0);
      chk("reissue_code3", 8'(A_bar), 8'h04);
      step(0, 0, 8'hFF, 1);
      step(0, 0, 8'hFF, 0);
      step(0, 0, 8'hFF, 0);

      // enable gating
      step(0, 1, 8'hEF, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 8'hFF, 0);
      chk("gated_GS", 8'(GS_bar), 8'h01);
      chk("gated_EO", 8'(EO_bar), 8'h01);
      step(0, 0, 8'hFF, 0);
      chk("ungated_code4", 8'(A_bar), 8'h03);

      // async reset while presenting
      step(1, 0, 8'hFF, 0);
      chk("async_rst_GS", 8'(GS_bar), 8'h01);
      for (int i = 0; i < 3; i++) step(0, 0, 8'hFF, 0);
      chk("post_rst_idle", 8'(EO_bar), 8'h00);

      // held request with Ack every cycle
      for (int i = 0; i < 12; i++) step(0, 0, 8'hFD, 1);
      for (int i = 0; i < 6; i++) step(0, 0, 8'hFF, 1);

      // random traffic
      d_r = 8'hFF;
      for (int i = 0; i < 3000; i++) begin
         d_r = d_r ^ 8'($urandom & $urandom & $urandom);
         step(($urandom % 100) == 0, ($urandom % 8) == 0, d_r, ($urandom % 3) == 0);
      end

      @(negedge Clk);
      #1;
      chk("scoreboard_drained", 8'(q.size()), 8'h00);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
